// File: rtl/load_store_unit.sv
// Load/store unit: aligns byte/half/word accesses onto a 32-bit
// waitrequest-style bus and sign/zero-extends load results.
package lsu_pkg;
    typedef enum logic {
        UNSIGNED = 1'b0,
        SIGNED   = 1'b1
    } signedness_e;
endpackage

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  signedness_e signedness,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_wdata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    signedness_e sign_q;
    logic        is_store_q;
    logic [31:0] mem_addr_q;
    logic        read_q;
    logic        write_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic [31:0] load_q;

    logic        misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted;
    logic [31:0] load_d;

    always_comb begin
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = store_data;
        unique case (size)
            2'd0: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            2'd1: begin
                misaligned = addr[0];
                be_d       = 4'b0011 << addr[1:0];
                wdata_d    = {2{store_data[15:0]}};
            end
            2'd2: begin
                misaligned = |addr[1:0];
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Extraction uses the latched request, not the live inputs.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        load_d  = shifted;
        unique case (size_q)
            2'd0: begin
                if (sign_q == SIGNED)
                    load_d = {{24{shifted[7]}}, shifted[7:0]};
                else
                    load_d = {24'b0, shifted[7:0]};
            end
            2'd1: begin
                if (sign_q == SIGNED)
                    load_d = {{16{shifted[15]}}, shifted[15:0]};
                else
                    load_d = {16'b0, shifted[15:0]};
            end
            default: begin
                load_d = shifted;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            sign_q     <= UNSIGNED;
            is_store_q <= 1'b0;
            mem_addr_q <= 32'd0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            load_q     <= 32'd0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start && misaligned) begin
                        error_q <= 1'b1;
                    end else if (start) begin
                        state_q    <= ACCESS;
                        cnt_q      <= 8'd0;
                        off_q      <= addr[1:0];
                        size_q     <= size;
                        sign_q     <= signedness;
                        is_store_q <= is_store;
                        mem_addr_q <= {addr[31:2], 2'b00};
                        read_q     <= ~is_store;
                        write_q    <= is_store;
                        be_q       <= be_d;
                        wdata_q    <= wdata_d;
                        busy_q     <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (!mem_waitrequest) begin
                        state_q <= RESP;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        done_q  <= 1'b1;
                        if (!is_store_q)
                            load_q <= load_d;
                    end else if (cnt_q == CntLast) begin
                        // Bus never answered: abort without touching load_q.
                        state_q <= IDLE;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        cnt_q   <= cnt_q + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_read       = read_q;
    assign mem_write      = write_q;
    assign mem_byteenable = be_q;
    assign mem_wdata      = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign load_data      = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: latency, lanes, extension,
// misalignment, timeout and mid-access reset.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [1:0]  size;
    signedness_e signedness;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_wdata;
    logic        mem_waitrequest;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        error;

    int checks;
    int failures;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .is_store       (is_store),
        .size           (size),
        .signedness     (signedness),
        .addr           (addr),
        .store_data     (store_data),
        .mem_addr       (mem_addr),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_wdata      (mem_wdata),
        .mem_waitrequest(mem_waitrequest),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .done           (done),
        .load_data      (load_data),
        .error          (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic st, input logic [1:0] sz,
                       input signedness_e sg, input logic [31:0] a,
                       input logic [31:0] sd);
        start      = 1'b1;
        is_store   = st;
        size       = sz;
        signedness = sg;
        addr       = a;
        store_data = sd;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        start           = 1'b0;
        is_store        = 1'b0;
        size            = 2'd0;
        signedness      = UNSIGNED;
        addr            = 32'd0;
        store_data      = 32'd0;
        mem_waitrequest = 1'b0;
        mem_rdata       = 32'd0;
        tick();
        tick();
        check("rst_read", {31'd0, mem_read}, 32'd0);
        check("rst_write", {31'd0, mem_write}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_load", load_data, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_be", {28'd0, mem_byteenable}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        tick();

        // lb signed at 0x1003, no wait
        req(1'b0, 2'd0, SIGNED, 32'h0000_1003, 32'd0);
        mem_rdata = 32'h80FF_1234;
        tick();
        start = 1'b0;
        check("lb_read", {31'd0, mem_read}, 32'd1);
        check("lb_write", {31'd0, mem_write}, 32'd0);
        check("lb_addr", mem_addr, 32'h0000_1000);
        check("lb_be", {28'd0, mem_byteenable}, 32'h8);
        check("lb_busy", {31'd0, busy}, 32'd1);
        check("lb_done_n1", {31'd0, done}, 32'd0);
        tick();
        check("lb_done_n2", {31'd0, done}, 32'd1);
        check("lb_load", load_data, 32'hFFFF_FF80);
        check("lb_read_drop", {31'd0, mem_read}, 32'd0);
        tick();
        check("lb_done_pulse", {31'd0, done}, 32'd0);
        check("lb_idle", {31'd0, busy}, 32'd0);

        // lhu at 0x2002 with three wait cycles; a start while busy is ignored
        req(1'b0, 2'd1, UNSIGNED, 32'h0000_2002, 32'd0);
        mem_rdata       = 32'h9ABC_5678;
        mem_waitrequest = 1'b1;
        tick();
        req(1'b1, 2'd2, UNSIGNED, 32'h0000_3000, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            check("lhu_read_hold", {31'd0, mem_read}, 32'd1);
            check("lhu_write_hold", {31'd0, mem_write}, 32'd0);
            check("lhu_addr_hold", mem_addr, 32'h0000_2000);
            check("lhu_be_hold", {28'd0, mem_byteenable}, 32'hC);
            check("lhu_no_done", {31'd0, done}, 32'd0);
            tick();
        end
        start           = 1'b0;
        mem_waitrequest = 1'b0;
        check("lhu_read_n4", {31'd0, mem_read}, 32'd1);
        check("lhu_addr_n4", mem_addr, 32'h0000_2000);
        tick();
        check("lhu_done_n5", {31'd0, done}, 32'd1);
        check("lhu_load", load_data, 32'h0000_9ABC);
        tick();
        check("lhu_no_queue", {31'd0, busy}, 32'd0);
        check("lhu_no_queue_w", {31'd0, mem_write}, 32'd0);

        // sb at 0x0001
        req(1'b1, 2'd0, UNSIGNED, 32'h0000_0001, 32'h1234_56A5);
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        check("sb_write", {31'd0, mem_write}, 32'd1);
        check("sb_read", {31'd0, mem_read}, 32'd0);
        check("sb_addr", mem_addr, 32'h0000_0000);
        check("sb_be", {28'd0, mem_byteenable}, 32'h2);
        check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        tick();
        check("sb_done", {31'd0, done}, 32'd1);
        check("sb_load_kept", load_data, 32'h0000_9ABC);
        tick();

        // sh at 0x0102: upper lanes, replicated halfword
        req(1'b1, 2'd1, UNSIGNED, 32'h0000_0102, 32'hCAFE_BEEF);
        tick();
        start = 1'b0;
        check("sh_be", {28'd0, mem_byteenable}, 32'hC);
        check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        tick();
        tick();

        // lw misaligned at 0x0006
        req(1'b0, 2'd2, UNSIGNED, 32'h0000_0006, 32'd0);
        tick();
        start = 1'b0;
        check("mis_error", {31'd0, error}, 32'd1);
        check("mis_read", {31'd0, mem_read}, 32'd0);
        check("mis_busy", {31'd0, busy}, 32'd0);
        tick();
        check("mis_error_pulse", {31'd0, error}, 32'd0);
        check("mis_read2", {31'd0, mem_read}, 32'd0);
        check("mis_busy2", {31'd0, busy}, 32'd0);

        // size 3 is always misaligned
        req(1'b0, 2'd3, UNSIGNED, 32'h0000_0000, 32'd0);
        tick();
        start = 1'b0;
        check("sz3_error", {31'd0, error}, 32'd1);
        check("sz3_busy", {31'd0, busy}, 32'd0);
        tick();

        // timeout: waitrequest stuck high, TIMEOUT = 4
        req(1'b0, 2'd2, UNSIGNED, 32'h0000_0010, 32'd0);
        mem_waitrequest = 1'b1;
        tick();
        start = 1'b0;
        check("to_read_n1", {31'd0, mem_read}, 32'd1);
        tick();
        tick();
        tick();
        check("to_read_n4", {31'd0, mem_read}, 32'd1);
        check("to_no_err_n4", {31'd0, error}, 32'd0);
        tick();
        check("to_error", {31'd0, error}, 32'd1);
        check("to_read_drop", {31'd0, mem_read}, 32'd0);
        check("to_no_done", {31'd0, done}, 32'd0);
        check("to_idle", {31'd0, busy}, 32'd0);
        check("to_load_kept", load_data, 32'h0000_9ABC);
        tick();
        check("to_error_pulse", {31'd0, error}, 32'd0);

        // next start accepted: lbu at 0x0011
        mem_waitrequest = 1'b0;
        mem_rdata       = 32'h0000_C300;
        req(1'b0, 2'd0, UNSIGNED, 32'h0000_0011, 32'd0);
        tick();
        start = 1'b0;
        check("after_to_read", {31'd0, mem_read}, 32'd1);
        check("after_to_be", {28'd0, mem_byteenable}, 32'h2);
        tick();
        check("after_to_done", {31'd0, done}, 32'd1);
        check("after_to_load", load_data, 32'h0000_00C3);
        tick();

        // lh signed at 0x0020
        mem_rdata = 32'h1234_8001;
        req(1'b0, 2'd1, SIGNED, 32'h0000_0020, 32'd0);
        tick();
        start = 1'b0;
        tick();
        check("lh_load", load_data, 32'hFFFF_8001);
        tick();

        // reset during ACCESS cycle 2 of a sw
        mem_waitrequest = 1'b1;
        req(1'b1, 2'd2, UNSIGNED, 32'h0000_0040, 32'hDEAD_BEEF);
        tick();
        start = 1'b0;
        check("sw_write", {31'd0, mem_write}, 32'd1);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw_be", {28'd0, mem_byteenable}, 32'hF);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_write", {31'd0, mem_write}, 32'd0);
        check("rr_done", {31'd0, done}, 32'd0);
        check("rr_error", {31'd0, error}, 32'd0);
        check("rr_busy", {31'd0, busy}, 32'd0);
        check("rr_load", load_data, 32'd0);
        check("rr_addr", mem_addr, 32'd0);
        check("rr_be", {28'd0, mem_byteenable}, 32'd0);
        check("rr_wdata", mem_wdata, 32'd0);
        tick();
        check("rr_done2", {31'd0, done}, 32'd0);
        check("rr_error2", {31'd0, error}, 32'd0);
        check("rr_write2", {31'd0, mem_write}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
